// File: rtl/mgmt_phy_controller_fsm.sv
// Controller-side LTPI PHY link-training FSM: comma hunt, detect, speed select, PLL retune,
// advertise, configure (with Configure retries) and operational, with error fallback to INIT.
module mgmt_phy_controller_fsm #(
  parameter int unsigned TIMER_1MS     = 60000,
  parameter int unsigned HUNT_MS       = 100,
  parameter int unsigned FRAME_LEN     = 15,
  parameter int unsigned MAX_CFG_RETRY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] tx_frm_offset,
  input  logic       aligned,
  input  logic       crc_consec_loss,
  input  logic       unexpected_frame_err,
  input  logic       frame_crc_err,
  input  logic       detect_locked,
  input  logic       sent_255_detect,
  input  logic       speed_locked,
  input  logic       speed_timeout,
  input  logic       pll_done,
  input  logic       change_freq_st,
  input  logic       advertise_locked,
  input  logic       auto_move_config,
  input  logic       trigger_config,
  input  logic       accept_frm_recv,
  input  logic       sw_reset,
  output logic       pll_reconfig,
  output logic       send_configure,
  output logic [3:0] link_state,
  output logic       link_lost,
  output logic [1:0] cfg_retry_cnt
);

  typedef enum logic [3:0] {
    ST_INIT     = 4'd0,
    ST_HUNT     = 4'd1,
    ST_DETECT   = 4'd2,
    ST_SPEED    = 4'd3,
    ST_SPD_CHG  = 4'd4,
    ST_ADV      = 4'd5,
    ST_WAIT_ADV = 4'd6,
    ST_CONFIG   = 4'd7,
    ST_OPER     = 4'd8,
    ST_OP_RST   = 4'd9,
    ST_LOST     = 4'd10
  } state_t;

  localparam logic [31:0] T1MS_LAST  = 32'(TIMER_1MS - 1);
  localparam logic [31:0] THUNT_LAST = 32'(TIMER_1MS * HUNT_MS - 1);
  localparam logic [3:0]  EOF_OFFSET = 4'(FRAME_LEN);
  localparam logic [1:0]  RETRY_LAST = 2'(MAX_CFG_RETRY - 1);

  state_t      r_state;
  logic [31:0] r_timer;
  logic        r_pll_reconfig;
  logic        r_send_configure;
  logic [3:0]  r_link_state;
  logic        r_link_lost;
  logic [1:0]  r_cfg_retry_cnt;

  state_t      w_next;
  logic        w_err;
  logic        w_eof;
  logic        w_t1ms;
  logic        w_thunt;
  logic        w_tmr_run;
  logic [31:0] w_tmr_lim;

  always_comb begin
    w_err     = crc_consec_loss | (unexpected_frame_err & ~frame_crc_err);
    w_eof     = (tx_frm_offset == EOF_OFFSET);
    w_t1ms    = (r_timer == T1MS_LAST);
    w_thunt   = (r_timer == THUNT_LAST);
    w_tmr_run = ((r_state == ST_HUNT) & change_freq_st) | (r_state == ST_ADV) |
                (r_state == ST_CONFIG);
    // Saturating at the state's own terminal count keeps t1ms a level, so eof-gated exits still fire
    w_tmr_lim = (r_state == ST_HUNT) ? THUNT_LAST : T1MS_LAST;

    w_next = r_state;
    case (r_state)
      ST_INIT:     if (pll_done) w_next = ST_HUNT;
      ST_HUNT: begin
        if (aligned)      w_next = change_freq_st ? ST_ADV : ST_DETECT;
        else if (w_thunt) w_next = ST_LOST;
      end
      ST_DETECT: begin
        if (w_err)                                         w_next = ST_LOST;
        else if (detect_locked & sent_255_detect & w_eof)  w_next = ST_SPEED;
      end
      ST_SPEED: begin
        if (w_err | speed_timeout)      w_next = ST_LOST;
        else if (speed_locked & w_eof)  w_next = ST_SPD_CHG;
      end
      ST_SPD_CHG:  if (pll_done) w_next = ST_HUNT;
      ST_ADV: begin
        if (w_err)                        w_next = ST_LOST;
        else if (w_t1ms) begin
          if (~advertise_locked)          w_next = ST_LOST;
          else if (~auto_move_config)     w_next = ST_WAIT_ADV;
          else if (w_eof)                 w_next = ST_CONFIG;
        end
      end
      ST_WAIT_ADV: begin
        if (w_err)                        w_next = ST_LOST;
        else if (trigger_config & w_eof)  w_next = ST_CONFIG;
      end
      ST_CONFIG: begin
        if (w_err)                        w_next = ST_LOST;
        else if (accept_frm_recv) begin
          if (w_eof)                      w_next = ST_OPER;
        end else if (w_t1ms) begin
          if (r_cfg_retry_cnt == RETRY_LAST) w_next = ST_LOST;
          else if (w_eof)                    w_next = ST_ADV;
        end
      end
      ST_OPER: begin
        if (w_err)         w_next = ST_LOST;
        else if (sw_reset) w_next = ST_OP_RST;
      end
      ST_OP_RST:   if (w_eof) w_next = ST_ADV;
      ST_LOST:     w_next = ST_INIT;
      default:     w_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= ST_INIT;
      r_timer          <= '0;
      r_pll_reconfig   <= 1'b0;
      r_send_configure <= 1'b0;
      r_link_state     <= '0;
      r_link_lost      <= 1'b0;
      r_cfg_retry_cnt  <= '0;
    end else begin
      r_state      <= w_next;
      r_link_state <= r_state;

      if (w_next != r_state)
        r_timer <= '0;
      else if (w_tmr_run && (r_timer != w_tmr_lim))
        r_timer <= r_timer + 32'd1;

      r_pll_reconfig   <= ((r_state == ST_INIT) | (r_state == ST_SPD_CHG)) & ~pll_done;
      r_send_configure <= (w_next == ST_CONFIG);
      r_link_lost      <= (w_next == ST_LOST);

      if ((r_state == ST_LOST) || (w_next == ST_OPER))
        r_cfg_retry_cnt <= '0;
      else if ((r_state == ST_CONFIG) && (w_next == ST_ADV))
        r_cfg_retry_cnt <= r_cfg_retry_cnt + 2'd1;
    end
  end

  assign pll_reconfig   = r_pll_reconfig;
  assign send_configure = r_send_configure;
  assign link_state     = r_link_state;
  assign link_lost      = r_link_lost;
  assign cfg_retry_cnt  = r_cfg_retry_cnt;

endmodule

// File: tb/tb_mgmt_phy_controller_fsm.sv
// Bench for mgmt_phy_controller_fsm: cycle-level behavioural model plus directed link-training scenarios.
module tb_mgmt_phy_controller_fsm;
  localparam int T1MS = 16;
  localparam int HMS  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] tx_frm_offset = '0;
  logic aligned = 0, crc_consec_loss = 0, unexpected_frame_err = 0, frame_crc_err = 0;
  logic detect_locked = 0, sent_255_detect = 0, speed_locked = 0, speed_timeout = 0;
  logic pll_done = 0, change_freq_st = 0, advertise_locked = 0, auto_move_config = 0;
  logic trigger_config = 0, accept_frm_recv = 0, sw_reset = 0;
  logic       pll_reconfig, send_configure, link_lost;
  logic [3:0] link_state;
  logic [1:0] cfg_retry_cnt;

  always #5 clk = ~clk;

  mgmt_phy_controller_fsm #(
    .TIMER_1MS(T1MS), .HUNT_MS(HMS), .FRAME_LEN(15), .MAX_CFG_RETRY(3)
  ) dut (
    .clk(clk), .reset(reset), .tx_frm_offset(tx_frm_offset), .aligned(aligned),
    .crc_consec_loss(crc_consec_loss), .unexpected_frame_err(unexpected_frame_err),
    .frame_crc_err(frame_crc_err), .detect_locked(detect_locked),
    .sent_255_detect(sent_255_detect), .speed_locked(speed_locked),
    .speed_timeout(speed_timeout), .pll_done(pll_done), .change_freq_st(change_freq_st),
    .advertise_locked(advertise_locked), .auto_move_config(auto_move_config),
    .trigger_config(trigger_config), .accept_frm_recv(accept_frm_recv), .sw_reset(sw_reset),
    .pll_reconfig(pll_reconfig), .send_configure(send_configure), .link_state(link_state),
    .link_lost(link_lost), .cfg_retry_cnt(cfg_retry_cnt)
  );

  int n_chk = 0, n_fail = 0;
  bit free_run = 1, done = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: state number, cycles spent in it, timed cycles, retries so far
  int m_state = 0, m_link = 0, m_tick = 0, m_dwell = 0, m_cnt = 0;

  function automatic int model_next(input int s, input int tick, input int cnt);
    bit err, eof, t1, th;
    err = crc_consec_loss || (unexpected_frame_err && !frame_crc_err);
    eof = (tx_frm_offset == 4'd15);
    t1  = (tick >= T1MS - 1);
    th  = (tick >= T1MS * HMS - 1);
    case (s)
      0:  return pll_done ? 1 : 0;
      1:  begin
            if (aligned) return change_freq_st ? 5 : 2;
            return th ? 10 : 1;
          end
      2:  begin
            if (err) return 10;
            return (detect_locked && sent_255_detect && eof) ? 3 : 2;
          end
      3:  begin
            if (err || speed_timeout) return 10;
            return (speed_locked && eof) ? 4 : 3;
          end
      4:  return pll_done ? 1 : 4;
      5:  begin
            if (err || (t1 && !advertise_locked)) return 10;
            if (t1 && !auto_move_config) return 6;
            return (t1 && eof) ? 7 : 5;
          end
      6:  begin
            if (err) return 10;
            return (trigger_config && eof) ? 7 : 6;
          end
      7:  begin
            if (err) return 10;
            if (accept_frm_recv) return eof ? 8 : 7;
            if (t1) begin
              if (cnt == 2) return 10;
              return eof ? 5 : 7;
            end
            return 7;
          end
      8:  begin
            if (err) return 10;
            return sw_reset ? 9 : 8;
          end
      9:  return eof ? 5 : 9;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int nxt;
    bit run;
    if (reset) begin
      m_state = 0; m_link = 0; m_tick = 0; m_dwell = 0; m_cnt = 0;
    end else begin
      nxt = model_next(m_state, m_tick, m_cnt);
      run = (m_state == 1 && change_freq_st) || m_state == 5 || m_state == 7;
      if (m_state == 7 && nxt == 5) m_cnt++;
      if (m_state == 10 || nxt == 8) m_cnt = 0;
      m_link = m_state;
      if (nxt != m_state) begin
        m_tick = 0; m_dwell = 0;
      end else begin
        m_dwell++;
        if (run) m_tick++;
      end
      m_state = nxt;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!done) begin
      chk("link_state", int'(link_state), m_link);
      chk("pll_reconfig", int'(pll_reconfig), int'((m_state == 0 || m_state == 4) && m_dwell > 0));
      chk("send_configure", int'(send_configure), int'(m_state == 7));
      chk("link_lost", int'(link_lost), int'(m_state == 10));
      chk("cfg_retry_cnt", int'(cfg_retry_cnt), m_cnt);
    end
  end

  task automatic tick();
    @(negedge clk);
    if (free_run) tx_frm_offset = tx_frm_offset + 4'd1;
  endtask

  task automatic wait_link(input int code, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (int'(link_state) == code) begin ok = 1; break; end
    end
    chk($sformatf("reach_state_%0d", code), int'(ok), 1);
  endtask

  task automatic wait_lost(input int budget, output int cycles);
    cycles = 0;
    while (!link_lost && cycles < budget) begin
      tick();
      cycles++;
    end
    chk("link_lost_seen", int'(link_lost), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    chk("rst_link_state", int'(link_state), 0);
    chk("rst_pll_reconfig", int'(pll_reconfig), 0);
    chk("rst_send_configure", int'(send_configure), 0);
    chk("rst_cfg_retry_cnt", int'(cfg_retry_cnt), 0);
    reset = 0;

    // Bring-up: INIT -> HUNT -> DETECT -> SPEED -> SPD_CHG
    repeat (3) tick();
    chk("init_pll_req", int'(pll_reconfig), 1);
    pll_done = 1;
    wait_link(1, 5);
    pll_done = 0;
    aligned = 1;
    wait_link(2, 5);
    detect_locked = 1; sent_255_detect = 1;
    wait_link(3, 40);
    speed_locked = 1;
    wait_link(4, 40);
    detect_locked = 0; sent_255_detect = 0; speed_locked = 0;
    tick();
    chk("spdchg_pll_req", int'(pll_reconfig), 1);

    // Retune, re-hunt at speed, advertise, configure, operational
    change_freq_st = 1; pll_done = 1;
    wait_link(5, 10);
    pll_done = 0; advertise_locked = 1; auto_move_config = 1;
    wait_link(7, 60);
    accept_frm_recv = 1;
    wait_link(8, 40);
    accept_frm_recv = 0;
    chk("oper_cfg_cnt", int'(cfg_retry_cnt), 0);
    chk("oper_send_cfg", int'(send_configure), 0);

    // Software reset: OP_RST held until the last frame byte
    auto_move_config = 0;
    free_run = 0; tx_frm_offset = 4'd3; sw_reset = 1;
    tick();
    sw_reset = 0;
    for (int off = 4; off <= 14; off++) begin
      tx_frm_offset = 4'(off);
      tick();
      chk("op_rst_hold", int'(link_state), 9);
    end
    tx_frm_offset = 4'd15;
    wait_link(5, 4);
    free_run = 1;
    wait_link(6, 40);
    repeat (20) tick();
    chk("wait_adv_hold", int'(link_state), 6);
    trigger_config = 1;
    wait_link(7, 40);
    trigger_config = 0; auto_move_config = 1;

    // Configure never accepted: two retries, then LINK_LOST
    wait_link(5, 60);
    chk("retry_cnt_1", int'(cfg_retry_cnt), 1);
    wait_link(7, 60);
    wait_link(5, 60);
    chk("retry_cnt_2", int'(cfg_retry_cnt), 2);
    wait_lost(80, cyc);
    chk("lost_cnt_held", int'(cfg_retry_cnt), 2);
    tick();
    chk("lost_state_code", int'(link_state), 10);
    chk("lost_pulse_1cyc", int'(link_lost), 0);
    chk("lost_cnt_clear", int'(cfg_retry_cnt), 0);

    // Comma hunt at operational speed times out after 64 timed cycles
    aligned = 0; pll_done = 1;
    wait_link(1, 10);
    pll_done = 0;
    wait_lost(100, cyc);
    chk("hunt_timeout_cycles", cyc, 63);

    // Advertise never locks
    repeat (2) tick();
    pll_done = 1;
    wait_link(1, 10);
    pll_done = 0; aligned = 1; advertise_locked = 0;
    wait_link(5, 10);
    wait_lost(40, cyc);

    // Error qualification in OPER
    repeat (2) tick();
    aligned = 0; advertise_locked = 1; pll_done = 1;
    wait_link(1, 10);
    pll_done = 0; aligned = 1;
    wait_link(7, 60);
    accept_frm_recv = 1;
    wait_link(8, 40);
    accept_frm_recv = 0;
    unexpected_frame_err = 1; frame_crc_err = 1;
    repeat (4) tick();
    chk("err_masked_by_crc", int'(link_state), 8);
    frame_crc_err = 0;
    wait_lost(10, cyc);
    unexpected_frame_err = 0;

    // Asynchronous reset in the middle of CONFIG
    repeat (2) tick();
    aligned = 0; pll_done = 1;
    wait_link(1, 10);
    pll_done = 0; aligned = 1;
    wait_link(7, 60);
    repeat (3) tick();
    chk("in_config_send", int'(send_configure), 1);
    #3 reset = 1;
    #1;
    chk("midrst_link_state", int'(link_state), 0);
    chk("midrst_send_cfg", int'(send_configure), 0);
    chk("midrst_pll", int'(pll_reconfig), 0);
    chk("midrst_lost", int'(link_lost), 0);
    tick();
    reset = 0;
    repeat (3) tick();
    chk("post_rst_state", int'(link_state), 0);

    done = 1;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
